id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core; directly upstream of the EX-stage forwarding unit and supplies it with ex_rs1/ex_rs2.
- Captures decoded operands and control each cycle.
- Detects load-use hazards against the instruction it currently holds, raises a stall toward PC/IF-ID, and inserts bubbles.
- Applies branch flushes and the WB-to-ID register-file bypass.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1, id_rs2, id_rd  in  REG_AW each  register addresses.
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data.
- id_imm  in  XLEN  immediate.
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch  in  1 each  decoded control.
- id_aluop  in  2  ALU op class.
- id_func3  in  3  instruction funct3.
- id_func7b5  in  1  instruction bit 30.
- wb_regwrite  in  1  MEM/WB write enable.
- wb_rd  in  REG_AW  MEM/WB destination.
- wb_data  in  XLEN  MEM/WB write-back value.
- flush  in  1  branch taken/redirect from EX.
- ex_* outputs  out  same widths as the id_* inputs, including ex_valid; registered copies.
- stall  out  1  combinational; load-use hazard detected.
- pc_write_en  out  1  combinational; ~stall.
- ifid_write_en  out  1  combinational; ~stall.

Behaviour:
- Reset (rst==0 at a clock edge) clears every registered output to 0. A zeroed stage is a bubble.
- Bubble definition:
  - ex_valid=0.
  - All control outputs 0.
  - ex_rd=ex_rs1=ex_rs2=0, so the downstream forwarding unit resolves to select 00.
  - Data, immediate and PC fields are also zeroed.
- Hazard: stall = ex_valid & ex_memread & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
- Next-state priority (highest first):
  1. Reset: bubble.
  2. flush=1: bubble; stall is forced to 0 in the same cycle (flush wins over hazard).
  3. stall=1: bubble, while PC and IF/ID hold via pc_write_en=ifid_write_en=0.
  4. id_valid=0: bubble.
  5. Otherwise: capture all id_* fields.
- WB bypass, applied independently to each operand when capturing:
  - if wb_regwrite & wb_rd!=0 & wb_rd==id_rsN, ex_rsN_data <= wb_data;
  - else ex_rsN_data <= id_rsN_data.
  - Covers the regfile write-then-read in the same cycle.
- Latency: exactly 1 cycle from ID to EX outputs. A load-use hazard costs exactly one bubble, after which the stalled instruction is captured on the next edge (the hazard clears because EX now holds the bubble).
- x0 is never a hazard or bypass source.
- Reset asserted during a stall clears the stage; stall deasserts combinationally because ex_valid=0.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- When defined, adds two outputs: stall_count[31:0] and flush_count[31:0].
  - stall_count increments on each cycle with stall=1 (after flush masking).
  - flush_count increments on each cycle with flush=1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset: rst=0 for 2 cycles with random id_* inputs -> all ex_* are 0, stall=0, pc_write_en=1.
- Normal capture: id_pc=32'h100, id_rs1=3, id_rs2=4, id_rd=5, id_rs1_data=32'hA, id_rs2_data=32'hB, id_valid=1 -> next cycle ex_pc=32'h100, ex_rd=5, ex_rs1_data=32'hA, ex_rs2_data=32'hB, ex_valid=1.
- Load-use: EX holds lw with rd=7 and ex_memread=1; ID has rs2=7 -> stall=1, pc_write_en=0, next ex_valid=0 and ex_rd=0; following cycle ex_rs2=7 is captured and stall=0.
- Flush over hazard: load-use condition present with flush=1 in the same cycle -> stall=0, next ex_valid=0 and all control outputs 0.
- WB bypass: id_rs1=9, id_rs1_data=32'h1, wb_regwrite=1, wb_rd=9, wb_data=32'hDEAD -> ex_rs1_data=32'hDEAD; repeat with wb_rd=0 -> ex_rs1_data=32'h1.
- x0 load: ex_memread=1, ex_rd=0, id_rs1=0 -> stall=0. With IDEX_PERF_CNT_EN defined, 3 stall cycles plus 2 flush cycles give stall_count=3 and flush_count=2.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Captures decoded operands and control each cycle.
// Detects load-use hazards against the held instruction and inserts bubbles.
// Applies branch flushes and the WB-to-ID register-file bypass.
// Optional build macro IDEX_PERF_CNT_EN adds the stall_count and flush_count
// performance counters; without it those ports and the counter logic are absent.
module id_ex_stage_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_alusrc,
    input  logic              id_branch,
    input  logic [1:0]        id_aluop,
    input  logic [2:0]        id_func3,
    input  logic              id_func7b5,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_alusrc,
    output logic              ex_branch,
    output logic [1:0]        ex_aluop,
    output logic [2:0]        ex_func3,
    output logic              ex_func7b5,
    output logic              stall,
    output logic              pc_write_en,
    output logic              ifid_write_en
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count
`endif
);

    // Whole stage held as one record so a bubble is simply an all-zero value.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic              alusrc;
        logic              branch;
        logic [1:0]        aluop;
        logic [2:0]        func3;
        logic              func7b5;
    } stage_t;

    stage_t q;
    stage_t capture;
    logic   load_use;
    logic   bubble;

    // Load-use detection against the held instruction; flush masks the stall.
    always_comb begin
        load_use = q.valid && q.memread && (q.rd != '0) && id_valid &&
                   ((q.rd == id_rs1) || (q.rd == id_rs2));
        stall         = load_use && !flush;
        pc_write_en   = !stall;
        ifid_write_en = !stall;
        bubble        = flush || stall || !id_valid;
    end

    // Build the captured record, forwarding a same-cycle WB write into rsN data.
    always_comb begin
        capture          = '0;
        capture.valid    = 1'b1;
        capture.pc       = id_pc;
        capture.rs1      = id_rs1;
        capture.rs2      = id_rs2;
        capture.rd       = id_rd;
        capture.rs1_data = (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
        capture.rs2_data = (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
        capture.imm      = id_imm;
        capture.regwrite = id_regwrite;
        capture.memread  = id_memread;
        capture.memwrite = id_memwrite;
        capture.memtoreg = id_memtoreg;
        capture.alusrc   = id_alusrc;
        capture.branch   = id_branch;
        capture.aluop    = id_aluop;
        capture.func3    = id_func3;
        capture.func7b5  = id_func7b5;
    end

    // Stage register: reset, flush, stall and empty ID all load a bubble.
    always_ff @(posedge clk) begin
        if (!rst)
            q <= '0;
        else if (bubble)
            q <= '0;
        else
            q <= capture;
    end

    assign ex_valid    = q.valid;
    assign ex_pc       = q.pc;
    assign ex_rs1      = q.rs1;
    assign ex_rs2      = q.rs2;
    assign ex_rd       = q.rd;
    assign ex_rs1_data = q.rs1_data;
    assign ex_rs2_data = q.rs2_data;
    assign ex_imm      = q.imm;
    assign ex_regwrite = q.regwrite;
    assign ex_memread  = q.memread;
    assign ex_memwrite = q.memwrite;
    assign ex_memtoreg = q.memtoreg;
    assign ex_alusrc   = q.alusrc;
    assign ex_branch   = q.branch;
    assign ex_aluop    = q.aluop;
    assign ex_func3    = q.func3;
    assign ex_func7b5  = q.func7b5;

`ifdef IDEX_PERF_CNT_EN
    // Saturating counts of stall cycles (after flush masking) and flush cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 32'd1;
            if (flush && (flush_count != '1))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
